// File: rtl/mul8_seq_ctrl.sv
// Sequencer for a shift-and-add unsigned multiplier driving an external 2*WIDTH-bit adder.
// One operand pair per accepted start; WIDTH add cycles, then a one-cycle done pulse.
module mul8_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   add_in1,
  output logic [2*WIDTH-1:0]   add_in2,
  input  logic [2*WIDTH-1:0]   add_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        cnt;
  logic                 last;

  assign last = (cnt == CW'(WIDTH - 1));

  // Outputs decode from state only, so start never reaches them combinationally.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    add_in1  = '0;
    add_in2  = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_in1 = acc;
        add_in2 = mplier_r[0] ? mcand_r : '0;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt      <= '0;
      product  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          acc      <= add_out;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt      <= cnt + 1'b1;
          if (last) product <= add_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed bench for mul8_seq_ctrl with a behavioural adder and a product scoreboard.
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] add_in1;
  logic [15:0] add_in2;
  logic [15:0] add_out;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign add_out = add_in1 + add_in2;

  mul8_seq_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .add_in1 (add_in1),
    .add_in2 (add_in2),
    .add_out (add_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding product.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      chk("done_expected", 16'(exp_q.size() > 0), 16'd1);
      if (exp_q.size() > 0) chk("product", product, exp_q.pop_front());
    end
  end

  // One operation; sample k is taken #1 after the k-th edge following the accept edge.
  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input int glitch_k, input bit chk2);
    logic [15:0] e;
    e = 16'(ia) * 16'(ib);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("busy_k%0d", k), 16'(busy), 16'(k <= 7));
      chk($sformatf("done_k%0d", k), 16'(done), 16'(k == 8));
      if (chk2 && k <= 7) chk($sformatf("add2_nz_k%0d", k), 16'(add_in2 != 16'h0), 16'd1);
      if (k >= 8) begin
        chk($sformatf("add1_zero_k%0d", k), add_in1, 16'h0);
        chk($sformatf("add2_zero_k%0d", k), add_in2, 16'h0);
      end
      if (k < 9) begin
        @(negedge clk);
        start = (glitch_k > 0 && k + 1 == glitch_k);
        if (start) begin
          a = 8'hFF; b = 8'hFF;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_product", product, 16'h0);
    chk("rst_add1", add_in1, 16'h0);
    chk("rst_add2", add_in2, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'h0D, 8'h0B, 0, 1'b0);
    op(8'hFF, 8'hFF, 0, 1'b1);
    op(8'h00, 8'hFF, 0, 1'b0);
    op(8'hFF, 8'h00, 0, 1'b0);
    op(8'h03, 8'h05, 4, 1'b0);

    // Abort mid-run: no done pulse, product cleared.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_product", product, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_nodone_%0d", i), 16'(done), 16'd0);
    end
    op(8'h12, 8'h34, 0, 1'b0);

    // Held start: accepts every 10 cycles, product holds between pulses.
    @(negedge clk);
    a = 8'h02; b = 8'h03; start = 1'b1;
    repeat (3) exp_q.push_back(16'h0006);
    @(posedge clk); #1;
    for (int t = 0; t < 30; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("held_done_t%0d", t), 16'(done), 16'(t % 10 == 8));
      chk($sformatf("held_prod_t%0d", t), product, (t >= 8) ? 16'h0006 : 16'h03A8);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
